// File: rtl/dmem_pkg.sv
// Shared constants and address decode for the data-side memory/MMIO unit.
package dmem_pkg;

  localparam logic [15:0] ADDR_LED    = 16'hFF00;
  localparam logic [15:0] ADDR_CYCLES = 16'hFF01;
  localparam logic [15:0] ADDR_FIFO   = 16'hFF02;
  localparam logic [15:0] ADDR_STATUS = 16'hFF03;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CYCLES,
    SEL_FIFO,
    SEL_STATUS
  } sel_e;

  // ram_hit comes from the caller since RAM size is a top parameter
  function automatic sel_e dmem_decode(
    input logic [15:0] addr,
    input logic        ram_hit
  );
    sel_e s;
    unique case (1'b1)
      ram_hit:              s = SEL_RAM;
      addr == ADDR_LED:     s = SEL_LED;
      addr == ADDR_CYCLES:  s = SEL_CYCLES;
      addr == ADDR_FIFO:    s = SEL_FIFO;
      addr == ADDR_STATUS:  s = SEL_STATUS;
      default:              s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_out_fifo.sv
// Byte-stream output FIFO; power-of-two depth, pointers wrap naturally.
module out_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [15:0]                din,
  output logic [15:0]                dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // a pop frees the slot in the same edge, so a full FIFO still accepts
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop_ok)  rd_d = rd_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory + MMIO (LED, cycle counter, output FIFO, status).
// Define DMEM_CYCLE_COUNTER_EN to include the CYCLES counter at 0xFF01.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  input  logic        WE,
  output logic [15:0] LED,
  output logic [15:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   ram_q [2**AW];
  logic [15:0]   led_q, led_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   rd_data;
  logic [15:0]   status;
  logic          ram_hit;
  sel_e          sel;
  logic          wr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  assign ram_hit = (DA >> AW) == 16'd0;
  assign sel     = dmem_decode(DA, ram_hit);
  assign wr      = WE && !RW && !RST;
  assign push    = wr && sel == SEL_FIFO;
  assign pop     = OUT_READY && !empty;

  assign DD        = RW ? rd_data : 'z;
  assign LED       = led_q;
  assign OUT_VALID = !empty;

  out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CK),
    .rst   (RST),
    .push  (push),
    .pop   (OUT_READY),
    .din   (DD),
    .dout  (OUT_DATA),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge CK) begin
    if (wr && sel == SEL_RAM) ram_q[DA[AW-1:0]] <= DD;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [15:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q + 16'd1;
    if (wr && sel == SEL_CYCLES) cycles_d = '0;
  end

  always_ff @(posedge CK) begin
    if (RST) cycles_q <= '0;
    else     cycles_q <= cycles_d;
  end
`endif

  always_comb begin
    led_d = led_q;
    ovf_d = ovf_q;
    if (wr && sel == SEL_LED) led_d = DD;
    if (push && full && !pop) ovf_d = 1'b1;
    if (wr && sel == SEL_STATUS && DD[ST_OVF]) ovf_d = 1'b0;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      led_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_EMPTY]               = empty;
    status[ST_FULL]                = full;
    status[ST_OVF]                 = ovf_q;
    status[ST_COUNT_LSB +: 4]      = 4'(count);
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      SEL_RAM:    rd_data = ram_q[DA[AW-1:0]];
      SEL_LED:    rd_data = led_q;
`ifdef DMEM_CYCLE_COUNTER_EN
      SEL_CYCLES: rd_data = cycles_q;
`endif
      SEL_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio against a queue/array reference model.
module tb_dmem_mmio;
  import dmem_pkg::*;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] da = '0;
  logic [15:0] dd_drv = '0;
  logic        rw = 1'b0;
  logic        we = 1'b0;
  logic        out_ready = 1'b0;
  wire  [15:0] DD;
  logic [15:0] led;
  logic [15:0] out_data;
  logic        out_valid;

  int nchk = 0;
  int nfail = 0;

  logic [15:0] m_ram [1024];
  bit          m_known [1024];
  logic [15:0] m_led;
  logic [15:0] m_cyc;
  logic [15:0] m_q [$];
  bit          m_ovf;

  assign DD = rw ? 'z : dd_drv;

  always #5 ck = ~ck;

  dmem_mmio #(
    .AW         (10),
    .FIFO_DEPTH (8)
  ) dut (
    .CK        (ck),
    .RST       (rst),
    .DA        (da),
    .DD        (DD),
    .RW        (rw),
    .WE        (we),
    .LED       (led),
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rd(input logic [15:0] a,
                                output logic [15:0] v);
    int n;
    n = m_q.size();
    v = '0;
    exp_rd = 1'b1;
    if (a < 16'd1024) begin
      v = m_ram[a[9:0]];
      exp_rd = m_known[a[9:0]];
    end else if (a == 16'hFF00) begin
      v = m_led;
    end else if (a == 16'hFF01) begin
`ifdef DMEM_CYCLE_COUNTER_EN
      v = m_cyc;
`endif
    end else if (a == 16'hFF03) begin
      v = {8'h00, 4'(n), 1'b0, m_ovf, n == 8, n == 0};
    end
  endfunction

  task automatic model_step();
    bit wrt;
    bit full;
    bit pop;
    wrt  = we && !rw;
    full = m_q.size() == 8;
    pop  = out_ready && m_q.size() != 0;
    if (rst) begin
      m_led = '0;
      m_cyc = '0;
      m_ovf = 1'b0;
      m_q.delete();
    end else begin
      m_cyc = m_cyc + 16'd1;
      if (pop) void'(m_q.pop_front());
      if (wrt) begin
        if (da < 16'd1024) begin
          m_ram[da[9:0]]   = dd_drv;
          m_known[da[9:0]] = 1'b1;
        end else if (da == 16'hFF00) begin
          m_led = dd_drv;
        end else if (da == 16'hFF01) begin
          m_cyc = '0;
        end else if (da == 16'hFF02) begin
          if (!full || pop) m_q.push_back(dd_drv);
          else m_ovf = 1'b1;
        end else if (da == 16'hFF03) begin
          if (dd_drv[2]) m_ovf = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit has_x = 1'b0,
                     input logic [15:0] xv = '0,
                     input string tag = "");
    logic [15:0] e;
    bit k;
    @(negedge ck);
    if (rw) begin
      k = exp_rd(da, e);
      if (k) chk("rd_model", DD, e);
      if (has_x) chk(tag, DD, xv);
    end
    chk("out_valid", {15'b0, out_valid}, {15'b0, m_q.size() != 0});
    chk("out_data", out_data, m_q.size() != 0 ? m_q[0] : 16'h0000);
    chk("led", led, m_led);
    @(posedge ck);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    rw = 1'b0; we = 1'b1; da = a; dd_drv = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rdx(input logic [15:0] a, input logic [15:0] v,
                     input string tag);
    rw = 1'b1; we = 1'b0; da = a;
    cyc(1'b1, v, tag);
    rw = 1'b0;
  endtask

  task automatic idle();
    rw = 1'b0; we = 1'b0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    m_led = '0; m_cyc = '0; m_ovf = 1'b0;

    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    rdx(ADDR_LED, 16'h0000, "rst_led");
    rdx(ADDR_STATUS, 16'h0001, "rst_status");

    wr(16'h0005, 16'hBEEF);
    rdx(16'h0005, 16'hBEEF, "ram_rd");
    wr(16'h8000, 16'h1234);
    rdx(16'h8000, 16'h0000, "unmapped");
    wr(ADDR_LED, 16'h5A5A);
    rdx(ADDR_LED, 16'h5A5A, "led_rd");
    rdx(ADDR_FIFO, 16'h0000, "fifo_rd0");

    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(ADDR_FIFO, 16'h0100 + 16'(i));
    rdx(ADDR_STATUS, 16'h0086, "st_ovf");
    wr(ADDR_STATUS, 16'h0004);
    rdx(ADDR_STATUS, 16'h0082, "st_clr");

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) wr(ADDR_FIFO, 16'h0200 + 16'(i));
    out_ready = 1'b0;
    rdx(ADDR_STATUS, 16'h0082, "st_stream");
    out_ready = 1'b1;
    repeat (8) idle();
    out_ready = 1'b0;
    rdx(ADDR_STATUS, 16'h0001, "st_drained");

`ifdef DMEM_CYCLE_COUNTER_EN
    wr(ADDR_CYCLES, 16'hAAAA);
    repeat (3) idle();
    rdx(ADDR_CYCLES, 16'h0003, "cyc_3");
    wr(ADDR_CYCLES, 16'h0000);
    repeat (65535) idle();
    rdx(ADDR_CYCLES, 16'hFFFF, "cyc_max");
    rdx(ADDR_CYCLES, 16'h0000, "cyc_wrap");
`else
    wr(ADDR_CYCLES, 16'h0005);
    rdx(ADDR_CYCLES, 16'h0000, "cyc_off");
`endif

    for (int i = 0; i < 4; i++) wr(ADDR_FIFO, 16'h0300 + 16'(i));
    rst = 1'b1;
    wr(ADDR_LED, 16'hFFFF);
    rst = 1'b0;
    chk("rst_valid", {15'b0, out_valid}, 16'h0000);
    rdx(ADDR_STATUS, 16'h0001, "rst_fifo");
    rdx(ADDR_LED, 16'h0000, "rst_store");

    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)       da = 16'($urandom_range(0, 15));
      else if (r == 4) da = ADDR_LED;
      else if (r == 5) da = ADDR_CYCLES;
      else if (r < 8)  da = ADDR_FIFO;
      else if (r == 8) da = ADDR_STATUS;
      else             da = 16'($urandom);
      rw        = $urandom_range(0, 2) == 0;
      we        = !rw && $urandom_range(0, 1) == 1;
      dd_drv    = 16'($urandom);
      out_ready = $urandom_range(0, 2) == 0;
      rst       = $urandom_range(0, 99) == 0;
      cyc();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory and memory-mapped I/O unit, directly downstream of the 16-bit CPU's data port. It serves CPU loads and stores over the shared tri-state data bus, backed by a word-addressed RAM, an LED output register, a free-running cycle counter and a byte-stream output FIFO. The FIFO is drained by an external consumer over a valid/ready handshake.

## Interface
- AW, 10, RAM address width; RAM holds 2^AW 16-bit words (AW ≤ 15).
- FIFO_DEPTH, 8, output FIFO entries; power of two, 2..16.

- CK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- DA  in  16  word address from CPU.
- DD  inout  16  data bus; block drives it only when RW=1, else high-Z.
- RW  in  1  1 = CPU read (block drives DD), 0 = CPU drives DD.
- WE  in  1  write strobe, one cycle per store; ignored when RW=1.
- LED  out  16  LED register contents.
- OUT_DATA  out  16  FIFO head word.
- OUT_VALID  out  1  FIFO non-empty.
- OUT_READY  in  1  consumer accepts head this cycle.

## Operation
- Memory map (DA):
  - 0x0000..2^AW-1: RAM.
  - 0xFF00 LED: read/write.
  - 0xFF01 CYCLES: read = counter; any write clears it to 0.
  - 0xFF02 FIFO: write pushes DD[15:0]; read returns 0.
  - 0xFF03 STATUS: read = {8'b0, count[3:0], 1'b0, ovf, full, empty}; write with DD[2]=1 clears ovf; other bits ignored.
  - All other addresses: read 0, writes dropped.
- Read: DD = decoded read data of DA, combinational, whenever RW=1.
- Write: committed at posedge when WE=1 and RW=0, data = DD sampled that edge.
- Counter: +1 every cycle, wraps 0xFFFF→0x0000; a CYCLES write in the same cycle wins (result 0).
- FIFO push when full: data dropped, ovf set (sticky until cleared or reset).
- FIFO pop at posedge when OUT_VALID && OUT_READY.
- Push and pop in the same cycle:
  - Full: both occur, count unchanged, no ovf.
  - Empty: push only; the pop condition is false since OUT_VALID=0.
- ovf-clear write and overflowing push cannot coincide (single write port).

## Timing
- Reset values: LED=0, CYCLES=0, FIFO empty (OUT_VALID=0, OUT_DATA=0), ovf=0, DD high-Z. RAM contents are not reset.
- Read latency 0 (same-cycle combinational); a write is visible to reads from the next cycle.
- Push → OUT_VALID high the next cycle.
- Back-to-back pops at one word per cycle while OUT_READY=1.
- OUT_DATA is stable while OUT_VALID=1 and no pop has occurred.
- RST mid-transfer: FIFO contents are discarded and any pending store is ignored in the reset cycle.

## Configuration
- DMEM_CYCLE_COUNTER_EN defined: CYCLES register present as described.
- Not defined: counter logic is removed; 0xFF01 behaves as unmapped (reads 0, writes dropped).

## Structure
- Package dmem_pkg holds:
  - Address constants ADDR_LED, ADDR_CYCLES, ADDR_FIFO, ADDR_STATUS.
  - STATUS bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_COUNT_LSB=4).
- One sub-module, out_fifo: parameterized FIFO_DEPTH, push/pop/full/empty/count, read/write pointers wrapping modulo depth.

## Test plan
- Reset then read 0xFF00, 0xFF03 → 0x0000 and 0x0001 (empty); DD high-Z while RW=0.
- Write 0xBEEF to RAM 0x0005, read next cycle → 0xBEEF; write to 0x8000 → subsequent read 0x0000.
- Push 9 words into the depth-8 FIFO with OUT_READY=0 → STATUS = 0x0086 (count 8, full, ovf). Write STATUS with DD=0x0004 → ovf=0.
- Fill FIFO, hold OUT_READY=1 while pushing each cycle → count stays 8, ovf stays 0, OUT_DATA sequence is in push order.
- DMEM_CYCLE_COUNTER_EN: write CYCLES, read 3 cycles later → 0x0003. Force counter to 0xFFFF, read next cycle → 0x0000. Without the macro, reads → 0.
- Assert RST while FIFO holds 4 words → next cycle OUT_VALID=0 and STATUS=0x0001.
